dct_pass_sequencer: RTL and testbench

Controller for the 2-D 8x8 DCT datapath: it sequences one block through load, row pass, column pass and readout. It generates all buffer addresses, coefficient indices and MAC clear/write strobes around a shared single-MAC engine. It sits between the input sample stream and the output stream, and owns the block-level counters; the datapath holds no control state.

---
 rtl/dct_pass_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_dct_pass_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_pass_sequencer.sv
// dct_pass_sequencer
// Block-level controller for the 2-D NxN DCT built around one shared MAC.
// A block moves through these phases:
//   LOAD     accept N*N input samples in raster order
//   ROW      row pass
//   DRAIN_R  wait for the last row result to leave the MAC pipeline
//   COL      column pass
//   DRAIN_C  wait for the last column result
//   OUT      hand out N*N readout addresses
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   en                compute enable; low freezes ROW/COL/DRAIN and the result pipe
//   in_valid/in_ready input sample handshake; buf_we/buf_waddr write the input buffer
//   pass              0 = row pass, 1 = column pass
//   mac_en            MAC operand issue
//   rd_addr           operand address
//   coef_addr         coefficient address {u,k}
//   mac_clr           clear the accumulator with this issue
//   res_we/res_waddr  result write, PIPE enabled cycles after the k==N-1 issue
//   out_valid/out_ready/out_addr/out_last  readout address stream
//   busy              high in any state other than LOAD
//   done              one-cycle pulse after the final readout handshake
module dct_pass_sequencer #(
  parameter int N_LOG2 = 3,
  parameter int PIPE   = 2,
  localparam int K     = 2 * N_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         buf_we,
  output logic [K-1:0] buf_waddr,
  output logic         pass,
  output logic         mac_en,
  output logic [K-1:0] rd_addr,
  output logic [K-1:0] coef_addr,
  output logic         mac_clr,
  output logic         res_we,
  output logic [K-1:0] res_waddr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_addr,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int IW = 3 * N_LOG2;
  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [2:0] {LOAD, ROW, DRAIN_R, COL, DRAIN_C, OUT} state_t;

  state_t state, state_nx;

  // Compute index triple packed as {i,u,k}. A single increment steps k
  // fastest, then u, then i, and wraps to zero after the last issue.
  logic [IW-1:0]     idx;
  logic [N_LOG2-1:0] ci, cu, ck;
  logic              idx_last;

  assign ci       = idx[IW-1 -: N_LOG2];
  assign cu       = idx[K-1 -: N_LOG2];
  assign ck       = idx[N_LOG2-1:0];
  assign idx_last = &idx;

  logic [DW-1:0] drain_cnt;
  logic          draining;
  logic          drain_done;

  assign draining   = (state == DRAIN_R) || (state == DRAIN_C);
  assign drain_done = draining && en && (drain_cnt == DW'(PIPE - 1));

  // Result delay line: one stage per MAC pipeline cycle.
  logic         dl_v [PIPE];
  logic [K-1:0] dl_a [PIPE];
  logic         dl_in_valid;
  logic [K-1:0] dl_in_addr;

  assign buf_we    = in_valid & in_ready;
  assign res_we    = en & dl_v[PIPE-1];
  assign res_waddr = dl_a[PIPE-1];
  assign busy      = (state != LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nx;
  end

  // Next-state and per-state outputs. A result is pushed into the delay
  // line only on the issue that completes a dot product (k == N-1).
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    pass        = 1'b0;
    mac_en      = 1'b0;
    rd_addr     = '0;
    coef_addr   = '0;
    mac_clr     = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    dl_in_valid = 1'b0;
    dl_in_addr  = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (&buf_waddr)) state_nx = ROW;
      end
      ROW: begin
        mac_en      = en;
        rd_addr     = {ci, ck};
        coef_addr   = {cu, ck};
        mac_clr     = en && (ck == '0);
        dl_in_valid = en && (&ck);
        dl_in_addr  = {ci, cu};
        if (en && idx_last) state_nx = DRAIN_R;
      end
      DRAIN_R: begin
        if (drain_done) state_nx = COL;
      end
      COL: begin
        pass        = 1'b1;
        mac_en      = en;
        rd_addr     = {ck, ci};
        coef_addr   = {cu, ck};
        mac_clr     = en && (ck == '0);
        dl_in_valid = en && (&ck);
        dl_in_addr  = {cu, ci};
        if (en && idx_last) state_nx = DRAIN_C;
      end
      DRAIN_C: begin
        pass = 1'b1;
        if (drain_done) state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_last  = (&out_addr);
        if (out_ready && (&out_addr)) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Block-level counters. The index is forced to zero while loading so every
  // ROW pass starts clean; COL starts from the natural wrap after ROW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_waddr <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      if (buf_we) buf_waddr <= buf_waddr + K'(1);

      if (state == LOAD)  idx <= '0;
      else if (mac_en)    idx <= idx + IW'(1);

      if (!draining)      drain_cnt <= '0;
      else if (drain_done) drain_cnt <= '0;
      else if (en)        drain_cnt <= drain_cnt + DW'(1);

      if (out_valid && out_ready) out_addr <= out_addr + K'(1);

      done <= out_valid && out_ready && out_last;
    end
  end

  // The delay line freezes with en so a stall delays result writes by
  // exactly the stall length; reset empties it so no stale write escapes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < PIPE; s++) begin
        dl_v[s] <= 1'b0;
        dl_a[s] <= '0;
      end
    end else if (en) begin
      dl_v[0] <= dl_in_valid;
      dl_a[0] <= dl_in_addr;
      for (int s = 1; s < PIPE; s++) begin
        dl_v[s] <= dl_v[s-1];
        dl_a[s] <= dl_a[s-1];
      end
    end
  end

endmodule

// File: tb/tb_dct_pass_sequencer.sv
// Directed testbench for dct_pass_sequencer with N_LOG2=3 (8x8) and PIPE=2.
// Inputs change and outputs are sampled on the falling clock edge.
// r counts cycles relative to ROW cycle 0 of the current block.
module tb_dct_pass_sequencer;

  localparam int N_LOG2 = 3;
  localparam int PIPE   = 2;
  localparam int K      = 2 * N_LOG2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, buf_we, pass, mac_en, mac_clr, res_we;
  logic         out_valid, out_last, busy, done;
  logic [K-1:0] buf_waddr, rd_addr, coef_addr, res_waddr, out_addr;

  int total = 0;
  int bad = 0;
  int r = 0;
  int wcount = 0;
  int wbase = 0;
  int exp_addr = 0;

  dct_pass_sequencer #(.N_LOG2(N_LOG2), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .buf_we(buf_we), .buf_waddr(buf_waddr),
    .pass(pass), .mac_en(mac_en), .rd_addr(rd_addr), .coef_addr(coef_addr),
    .mac_clr(mac_clr), .res_we(res_we), .res_waddr(res_waddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Running count of input-buffer writes.
  always @(posedge clk) if (buf_we) wcount++;

  task automatic applyStimulus(input logic iv, input logic e, input logic ordy);
    in_valid  = iv;
    en        = e;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic goRel(input int target);
    while (r < target) begin
      @(negedge clk);
      r++;
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("rst_buf_we", 32'(buf_we), 1);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_buf_waddr", 32'(buf_waddr), 0);
    checkOutput("rst_res_we", 32'(res_we), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_mac_en", 32'(mac_en), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // ---------------- block 1: back-to-back load ----------------
    wbase = wcount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 64; j++) begin
      checkOutput("load_waddr", 32'(buf_waddr), j);
      checkOutput("load_busy", 32'(busy), 0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    r = 0;
    checkOutput("t0_busy", 32'(busy), 1);
    checkOutput("t0_writes", wcount - wbase, 64);
    checkOutput("t0_waddr_wrap", 32'(buf_waddr), 0);
    checkOutput("t0_in_ready", 32'(in_ready), 0);
    checkOutput("t0_mac_en", 32'(mac_en), 1);
    checkOutput("t0_rd_addr", 32'(rd_addr), 0);
    checkOutput("t0_coef", 32'(coef_addr), 0);
    checkOutput("t0_mac_clr", 32'(mac_clr), 1);
    checkOutput("t0_pass", 32'(pass), 0);

    // ---------------- row pass ----------------
    goRel(8);
    checkOutput("row8_res_we", 32'(res_we), 0);
    goRel(9);
    checkOutput("row9_rd_addr", 32'(rd_addr), 1);
    checkOutput("row9_coef", 32'(coef_addr), 9);
    checkOutput("row9_mac_clr", 32'(mac_clr), 0);
    checkOutput("row9_res_we", 32'(res_we), 1);
    checkOutput("row9_res_waddr", 32'(res_waddr), 0);
    goRel(73);
    checkOutput("row73_res_we", 32'(res_we), 1);
    checkOutput("row73_res_waddr", 32'(res_waddr), 8);
    goRel(511);
    checkOutput("row511_rd_addr", 32'(rd_addr), 63);
    checkOutput("row511_coef", 32'(coef_addr), 63);
    checkOutput("row511_mac_en", 32'(mac_en), 1);
    goRel(512);
    checkOutput("drainr_mac_en", 32'(mac_en), 0);
    checkOutput("drainr_busy", 32'(busy), 1);
    checkOutput("drainr_pass", 32'(pass), 0);
    checkOutput("drainr_res_we0", 32'(res_we), 0);
    goRel(513);
    checkOutput("row_last_res_we", 32'(res_we), 1);
    checkOutput("row_last_res_waddr", 32'(res_waddr), 63);

    // ---------------- column pass ----------------
    goRel(514);
    checkOutput("col0_pass", 32'(pass), 1);
    checkOutput("col0_mac_en", 32'(mac_en), 1);
    checkOutput("col0_rd_addr", 32'(rd_addr), 0);
    checkOutput("col0_mac_clr", 32'(mac_clr), 1);
    checkOutput("col0_res_we", 32'(res_we), 0);
    goRel(522);
    checkOutput("col8_rd_addr", 32'(rd_addr), 0);
    checkOutput("col8_coef", 32'(coef_addr), 8);
    checkOutput("col8_mac_clr", 32'(mac_clr), 1);
    goRel(523);
    checkOutput("col9_rd_addr", 32'(rd_addr), 8);
    checkOutput("col9_coef", 32'(coef_addr), 9);
    checkOutput("col_first_res_we", 32'(res_we), 1);
    checkOutput("col_first_res_waddr", 32'(res_waddr), 0);
    goRel(587);
    checkOutput("col_i1_res_we", 32'(res_we), 1);
    checkOutput("col_i1_res_waddr", 32'(res_waddr), 1);
    goRel(1027);
    checkOutput("drainc_out_valid", 32'(out_valid), 0);
    checkOutput("drainc_pass", 32'(pass), 1);
    goRel(1028);
    checkOutput("out0_valid", 32'(out_valid), 1);
    checkOutput("out0_addr", 32'(out_addr), 0);
    checkOutput("out0_mac_en", 32'(mac_en), 0);

    // ---------------- readout with out_ready toggling 1,0 ----------------
    exp_addr = 0;
    for (int c = 0; c < 127; c++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 1);
      checkOutput("bp_out_addr", 32'(out_addr), exp_addr);
      checkOutput("bp_out_last", 32'(out_last), (exp_addr == 63) ? 1 : 0);
      checkOutput("bp_done", 32'(done), 0);
      applyStimulus(1'b0, 1'b1, (c % 2) == 0);
      if (out_ready) exp_addr++;
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("end1_done", 32'(done), 1);
    checkOutput("end1_busy", 32'(busy), 0);
    checkOutput("end1_in_ready", 32'(in_ready), 1);
    checkOutput("end1_out_valid", 32'(out_valid), 0);
    checkOutput("end1_out_addr", 32'(out_addr), 0);
    @(negedge clk);
    checkOutput("end1_done_pulse", 32'(done), 0);

    // ---------------- block 2: gapped load ----------------
    wbase = wcount;
    for (int c = 0; c < 190; c++) begin
      applyStimulus((c % 3) == 0, 1'b1, 1'b0);
      if ((c % 3) == 0) checkOutput("gap_waddr", 32'(buf_waddr), c / 3);
      if (c == 189) checkOutput("gap_still_load", 32'(in_ready), 1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    r = 0;
    checkOutput("gap_writes", wcount - wbase, 64);
    checkOutput("gap_busy", 32'(busy), 1);
    checkOutput("gap_mac_en", 32'(mac_en), 1);

    // ---------------- stall of 5 cycles at t0+100 ----------------
    goRel(100);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      #1;
      checkOutput("stall_mac_en", 32'(mac_en), 0);
      checkOutput("stall_res_we", 32'(res_we), 0);
      checkOutput("stall_rd_addr", 32'(rd_addr), 12);
      checkOutput("stall_coef", 32'(coef_addr), 36);
      @(negedge clk);
      r++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("resume_mac_en", 32'(mac_en), 1);
    checkOutput("resume_rd_addr", 32'(rd_addr), 12);
    goRel(109);
    checkOutput("resume_res_we0", 32'(res_we), 0);
    goRel(110);
    checkOutput("resume_res_we", 32'(res_we), 1);
    checkOutput("resume_res_waddr", 32'(res_waddr), 12);

    // ---------------- stall of 3 cycles with a result in flight ----------------
    goRel(204);
    checkOutput("pre_stall2_rd_addr", 32'(rd_addr), 31);
    goRel(205);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      #1;
      checkOutput("stall2_res_we", 32'(res_we), 0);
      @(negedge clk);
      r++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("stall2_res_we_r208", 32'(res_we), 0);
    goRel(209);
    checkOutput("stall2_res_we_r209", 32'(res_we), 1);
    checkOutput("stall2_res_waddr", 32'(res_waddr), 24);
    goRel(1035);
    checkOutput("stalled_out_valid_early", 32'(out_valid), 0);
    goRel(1036);
    checkOutput("stalled_out_valid", 32'(out_valid), 1);
    checkOutput("stalled_out_addr", 32'(out_addr), 0);

    // ---------------- block 2 readout at full rate ----------------
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 64; c++) begin
      if (c == 62) checkOutput("fr_out_last62", 32'(out_last), 0);
      if (c == 63) checkOutput("fr_out_last63", 32'(out_last), 1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("end2_done", 32'(done), 1);
    checkOutput("end2_busy", 32'(busy), 0);

    // ---------------- block 3: reset mid-ROW ----------------
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (64) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    r = 0;
    goRel(24);
    checkOutput("b3_mac_en", 32'(mac_en), 1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 1);
    checkOutput("midrst_res_we", 32'(res_we), 0);
    checkOutput("midrst_buf_waddr", 32'(buf_waddr), 0);
    checkOutput("midrst_mac_en", 32'(mac_en), 0);
    @(negedge clk);
    checkOutput("midrst_res_we_next", 32'(res_we), 0);
    checkOutput("midrst_busy_next", 32'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("postrst_busy", 32'(busy), 0);
    checkOutput("postrst_in_ready", 32'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
